// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller and the instruction decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_stall_ctrl_pkg;

  // Tuse/Tnew stage encodings: 0 = needed/ready in D, 1 = in E, 2 = in M.
  localparam int T_D = 0;
  localparam int T_E = 1;
  localparam int T_M = 2;

  // Multiply/divide start codes carried alongside the instruction.
  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10
  } md_op_e;

  // Counter width able to hold max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// D-stage hazard information in, stall/bubble decision out.
// Latency: purely wires; the controller answers in the same cycle.
// Backpressure: stall is the backpressure towards F/D; clr_E bubbles E.
//   master: decode side (drives D-stage fields, observes stall/clr_E/md_busy)
//   slave : hazard controller
interface hazard_stall_ctrl_if #(
  parameter int T_W = 2
);
  logic [4:0]     rs_D;
  logic [4:0]     rt_D;
  logic           use_rs_D;
  logic           use_rt_D;
  logic [T_W-1:0] tuse_rs_D;
  logic [T_W-1:0] tuse_rt_D;
  logic [4:0]     dst_D;
  logic [T_W-1:0] tnew_D;
  logic [1:0]     md_start_D;
  logic           md_use_D;
  logic           stall;
  logic           clr_E;
  logic           md_busy;

  modport master (
    output rs_D, rt_D, use_rs_D, use_rt_D, tuse_rs_D, tuse_rt_D,
           dst_D, tnew_D, md_start_D, md_use_D,
    input  stall, clr_E, md_busy
  );

  modport slave (
    input  rs_D, rt_D, use_rs_D, use_rt_D, tuse_rs_D, tuse_rt_D,
           dst_D, tnew_D, md_start_D, md_use_D,
    output stall, clr_E, md_busy
  );
endinterface

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Multiply/divide busy window: loads latency when a mult/div leaves E, then counts down.
// Latency: busy is combinational from the E-slot op and the registered count.
// Backpressure: none; the busy flag feeds the stall decision upstream.
//   clk, reset : clock, synchronous active-high reset
//   md_e_i     : md op currently in E
//   md_busy_o  : unit busy (op in E or count non-zero)
module md_busy_counter
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic   clk,
  input  logic   reset,
  input  md_op_e md_e_i,
  output logic   md_busy_o
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = cnt_width(MAX_LAT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A new op leaving E restarts the window rather than extending it.
  always_comb begin
    cnt_d = cnt_q;
    if (md_e_i == MD_MUL) begin
      cnt_d = CNT_W'(MUL_LAT);
    end else if (md_e_i == MD_DIV) begin
      cnt_d = CNT_W'(DIV_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign md_busy_o = (cnt_q != '0) || (md_e_i != MD_NONE);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: shadow scoreboard of E/M writers plus md busy window.
// Latency: stall/clr_E are same-cycle combinational; scoreboard updates 1 cycle after the edge.
// Backpressure: stall holds PC and F/D; clr_E inserts a bubble into the D->E register.
//   clk, reset : clock, synchronous active-high reset
//   hz         : D-stage sources/Tuse, destination/Tnew, md start/use in;
//                stall, clr_E, md_busy out
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int T_W     = 2
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  hz
);

  logic [4:0]     dst_e_q, dst_e_d;
  logic [T_W-1:0] tnew_e_q, tnew_e_d;
  md_op_e         md_e_q, md_e_d;
  logic [4:0]     dst_m_q, dst_m_d;
  logic [T_W-1:0] tnew_m_q, tnew_m_d;

  logic stall_rs;
  logic stall_rt;
  logic stall_md;
  logic stall_all;
  logic md_busy;

  // Register 0 never hazards; W is never checked because the register file writes through.
  assign stall_rs = hz.use_rs_D && (hz.rs_D != 5'd0) &&
                    (((dst_e_q == hz.rs_D) && (tnew_e_q > hz.tuse_rs_D)) ||
                     ((dst_m_q == hz.rs_D) && (tnew_m_q > hz.tuse_rs_D)));

  assign stall_rt = hz.use_rt_D && (hz.rt_D != 5'd0) &&
                    (((dst_e_q == hz.rt_D) && (tnew_e_q > hz.tuse_rt_D)) ||
                     ((dst_m_q == hz.rt_D) && (tnew_m_q > hz.tuse_rt_D)));

  md_busy_counter #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md (
    .clk       (clk),
    .reset     (reset),
    .md_e_i    (md_e_q),
    .md_busy_o (md_busy)
  );

  assign stall_md  = hz.md_use_D && md_busy;
  assign stall_all = stall_rs || stall_rt || stall_md;

  assign hz.stall   = stall_all;
  assign hz.clr_E   = stall_all;
  assign hz.md_busy = md_busy;

  // Slot shift: a stall turns the E entry into a bubble; M always advances.
  always_comb begin
    dst_e_d  = hz.dst_D;
    tnew_e_d = hz.tnew_D;
    md_e_d   = md_op_e'(hz.md_start_D);
    if (stall_all) begin
      dst_e_d  = 5'd0;
      tnew_e_d = '0;
      md_e_d   = MD_NONE;
    end
    dst_m_d  = dst_e_q;
    // Saturating decrement: a zero Tnew stays zero in M.
    tnew_m_d = (tnew_e_q == '0) ? '0 : (tnew_e_q - T_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dst_e_q  <= 5'd0;
      tnew_e_q <= '0;
      md_e_q   <= MD_NONE;
      dst_m_q  <= 5'd0;
      tnew_m_q <= '0;
    end else begin
      dst_e_q  <= dst_e_d;
      tnew_e_q <= tnew_e_d;
      md_e_q   <= md_e_d;
      dst_m_q  <= dst_m_d;
      tnew_m_q <= tnew_m_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed pipeline scenarios then random traffic,
// compared against a timeline model (absolute ready times of in-flight writers, last md window).
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam int T_W     = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.T_W(T_W)) hz ();

  hazard_stall_ctrl #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .T_W     (T_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [1:0] md_start;
    logic       md_use;
  } instr_t;

  // A writer that entered E at cycle te has its result usable from cycle te+tnew on;
  // it is visible to the scoreboard only while in E or M (cycles te, te+1).
  typedef struct {
    int te;
    int dst;
    int tnew;
  } wr_t;

  wr_t wq[$];
  int  md_te  = -1000;
  int  md_lat = 0;
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  function automatic instr_t mk(int rs, int urs, int trs, int rt, int urt, int trt,
                                int dst, int tnew, int mds, int mdu);
    instr_t i;
    i.rs = 5'(rs); i.use_rs = urs[0]; i.tuse_rs = 2'(trs);
    i.rt = 5'(rt); i.use_rt = urt[0]; i.tuse_rt = 2'(trt);
    i.dst = 5'(dst); i.tnew = 2'(tnew);
    i.md_start = 2'(mds); i.md_use = mdu[0];
    return i;
  endfunction

  function automatic bit src_hz(int src, bit use_src, int tuse);
    if (!use_src || src == 0) return 1'b0;
    foreach (wq[k]) begin
      if (wq[k].dst == src && (cyc - wq[k].te) >= 0 && (cyc - wq[k].te) <= 1 &&
          (wq[k].te + wq[k].tnew) > (cyc + tuse))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit model_busy();
    return (cyc >= md_te) && (cyc <= md_te + md_lat);
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_v(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // One pipeline cycle: present ins in D, check outputs mid-cycle, clock, advance model.
  task automatic step(input instr_t ins, input bit rst, output bit st);
    bit e_busy;
    bit e_stall;
    @(negedge clk);
    hz.rs_D = ins.rs; hz.rt_D = ins.rt;
    hz.use_rs_D = ins.use_rs; hz.use_rt_D = ins.use_rt;
    hz.tuse_rs_D = ins.tuse_rs; hz.tuse_rt_D = ins.tuse_rt;
    hz.dst_D = ins.dst; hz.tnew_D = ins.tnew;
    hz.md_start_D = ins.md_start; hz.md_use_D = ins.md_use;
    reset = rst;
    #1;
    e_busy  = model_busy();
    e_stall = src_hz(int'(ins.rs), ins.use_rs, int'(ins.tuse_rs)) ||
              src_hz(int'(ins.rt), ins.use_rt, int'(ins.tuse_rt)) ||
              (ins.md_use && e_busy);
    check("stall", hz.stall, e_stall);
    check("clr_E", hz.clr_E, e_stall);
    check("md_busy", hz.md_busy, e_busy);
    st = hz.stall;
    @(posedge clk);
    if (rst) begin
      wq.delete();
      md_te = -1000;
    end else if (!e_stall) begin
      if (ins.dst != 5'd0) wq.push_back('{cyc + 1, int'(ins.dst), int'(ins.tnew)});
      if (ins.md_start == MD_MUL) begin
        md_te = cyc + 1; md_lat = MUL_LAT;
      end else if (ins.md_start == MD_DIV) begin
        md_te = cyc + 1; md_lat = DIV_LAT;
      end
    end
    cyc++;
    while (wq.size() > 0 && (cyc - wq[0].te) > 1) void'(wq.pop_front());
  endtask

  initial begin
    instr_t nop, lw8, beq8, add9, use9_e, beq9, wr0, rd0, mult, divi, mflo, mfhi8, cur;
    bit s;
    int n;

    nop    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lw8    = mk(29, 1, T_E, 0, 0, 0, 8, T_M, 0, 0);
    beq8   = mk(8, 1, T_D, 0, 0, 0, 0, 0, 0, 0);
    add9   = mk(1, 1, T_E, 2, 1, T_E, 9, T_E, 0, 0);
    use9_e = mk(9, 1, T_E, 3, 1, T_E, 10, T_E, 0, 0);
    beq9   = mk(9, 1, T_D, 0, 0, 0, 0, 0, 0, 0);
    wr0    = mk(1, 1, T_E, 0, 0, 0, 0, T_E, 0, 0);
    rd0    = mk(0, 1, T_D, 0, 1, T_D, 0, 0, 0, 0);
    mult   = mk(4, 1, T_E, 5, 1, T_E, 0, 0, 1, 1);
    divi   = mk(4, 1, T_E, 5, 1, T_E, 0, 0, 2, 1);
    mflo   = mk(0, 0, 0, 0, 0, 0, 11, T_E, 0, 1);
    mfhi8  = mk(0, 0, 0, 8, 1, T_D, 12, T_E, 0, 1);

    hz.rs_D = '0; hz.rt_D = '0; hz.use_rs_D = 1'b0; hz.use_rt_D = 1'b0;
    hz.tuse_rs_D = '0; hz.tuse_rt_D = '0; hz.dst_D = '0; hz.tnew_D = '0;
    hz.md_start_D = '0; hz.md_use_D = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state (outputs checked inside step against an empty model).
    step(nop, 0, s);
    step(nop, 0, s);

    // Load followed by a branch on its result: two stall cycles.
    step(lw8, 0, s);
    step(beq8, 0, s); check("lw_beq_c1", s, 1'b1);
    step(beq8, 0, s); check("lw_beq_c2", s, 1'b1);
    step(beq8, 0, s); check("lw_beq_c3", s, 1'b0);
    repeat (2) step(nop, 0, s);

    // ALU result consumed in E: no stall; consumed by a branch in D: one stall.
    step(add9, 0, s);
    step(use9_e, 0, s); check("alu_use_e", s, 1'b0);
    repeat (2) step(nop, 0, s);
    step(add9, 0, s);
    step(beq9, 0, s); check("alu_beq_c1", s, 1'b1);
    step(beq9, 0, s); check("alu_beq_c2", s, 1'b0);
    repeat (2) step(nop, 0, s);

    // $0 never hazards.
    step(wr0, 0, s);
    step(rd0, 0, s); check("r0_c1", s, 1'b0);
    step(rd0, 0, s); check("r0_c2", s, 1'b0);

    // mult then mflo: MUL_LAT+1 stall cycles; div then mflo: DIV_LAT+1.
    step(mult, 0, s);
    n = 0; s = 1'b1;
    for (int k = 0; k < 40 && s; k++) begin step(mflo, 0, s); if (s) n++; end
    check_v("mult_stall_cycles", n, MUL_LAT + 1);
    step(divi, 0, s);
    n = 0; s = 1'b1;
    for (int k = 0; k < 40 && s; k++) begin step(mflo, 0, s); if (s) n++; end
    check_v("div_stall_cycles", n, DIV_LAT + 1);

    // Reset during the 3rd cycle of a div window.
    step(divi, 0, s);
    step(mflo, 0, s);
    step(mflo, 0, s);
    step(mflo, 1, s); check("rst_mid_div_stall", s, 1'b1);
    #1;
    check_v("rst_dst_e", int'(dut.dst_e_q), 0);
    check_v("rst_tnew_e", int'(dut.tnew_e_q), 0);
    check_v("rst_md_e", int'(dut.md_e_q), 0);
    check_v("rst_dst_m", int'(dut.dst_m_q), 0);
    check_v("rst_tnew_m", int'(dut.tnew_m_q), 0);
    check_v("rst_md_cnt", int'(dut.u_md.cnt_q), 0);
    step(mflo, 0, s); check("post_rst_stall", s, 1'b0);

    // Load hazard overlapping the tail of a mult window: one contiguous 3-cycle stall.
    step(mult, 0, s);
    step(nop, 0, s);
    step(nop, 0, s);
    step(lw8, 0, s);
    n = 0; s = 1'b1;
    for (int k = 0; k < 40 && s; k++) begin step(mfhi8, 0, s); if (s) n++; end
    check_v("lw_mfhi_stall_cycles", n, 3);
    repeat (2) step(nop, 0, s);

    // Random traffic; a stalled instruction stays in D until it issues.
    s = 1'b0;
    cur = nop;
    for (int k = 0; k < 600; k++) begin
      bit rst;
      int r;
      if (!s) begin
        cur = mk($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 2),
                 $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 2),
                 $urandom_range(0, 7), $urandom_range(0, 2), 0, 0);
        r = $urandom_range(0, 15);
        if (r == 0) cur.md_start = 2'b01;
        else if (r == 1) cur.md_start = 2'b10;
        cur.md_use = (cur.md_start != 2'b00) || ($urandom_range(0, 3) == 0);
      end
      rst = ($urandom_range(0, 199) == 0);
      step(cur, rst, s);
      if (rst) s = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
